// File: rtl/time_pkg.sv
// Shared constants for the time-domain blocks: time/counter widths and scheduler FSM encoding.
package time_pkg;

    localparam int unsigned TIME_W     = 32;
    localparam int unsigned LATE_CNT_W = 16;
    localparam int unsigned ST_W       = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_FIRE = 2'd2;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word fall-through FIFO with flush; head is the oldest stored word.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/time_cmd_sched.sv
// Timed command scheduler: queues commands tagged with a target time and releases them
// in order as one-cycle strobes when master_time reaches each target.
module time_cmd_sched
    import time_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CMD_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TIME_W-1:0]       master_time,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [TIME_W-1:0]       cmd_time,
    input  logic                    cmd_now,
    input  logic [CMD_W-1:0]        cmd_data,
    input  logic                    drop_late,
    input  logic                    flush,
    output logic                    out_stb,
    output logic [CMD_W-1:0]        out_data,
    output logic                    late,
    output logic [$clog2(DEPTH):0]  count,
    output logic [LATE_CNT_W-1:0]   late_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = 1 + TIME_W + CMD_W;

    logic [ENT_W-1:0]  wr_entry;
    logic [ENT_W-1:0]  head_entry;
    logic              head_now;
    logic [TIME_W-1:0] head_time;
    logic [CMD_W-1:0]  head_data;
    logic [TIME_W-1:0] diff;
    logic              head_due;
    logic              head_late;
    logic              push;
    logic              pop;
    logic              load;
    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_next;
    logic              stb_next;
    logic              late_next;

    assign cmd_ready = (count != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign wr_entry  = {cmd_now, cmd_time, cmd_data};
    assign {head_now, head_time, head_data} = head_entry;

    // Modular compare: a negative distance means the target is up to 2^31 cycles past.
    assign diff      = head_time - master_time;
    assign head_due  = (diff == '0);
    assign head_late = diff[TIME_W-1];

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_entry),
        .head  (head_entry),
        .count (count)
    );

    always_comb begin
        state_next = state;
        stb_next   = 1'b0;
        late_next  = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (count != '0) state_next = ST_WAIT;
                ST_WAIT: begin
                    if (head_now || head_due) begin
                        state_next = ST_FIRE;
                        stb_next   = 1'b1;
                        pop        = 1'b1;
                        load       = 1'b1;
                    end else if (head_late) begin
                        state_next = ST_FIRE;
                        stb_next   = !drop_late;
                        late_next  = 1'b1;
                        pop        = 1'b1;
                        load       = 1'b1;
                    end
                end
                ST_FIRE: state_next = (count != '0) ? ST_WAIT : ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            out_stb  <= 1'b0;
            late     <= 1'b0;
            out_data <= '0;
            late_cnt <= '0;
        end else begin
            state   <= state_next;
            out_stb <= stb_next;
            late    <= late_next;
            if (load) out_data <= head_data;
            if (late && (late_cnt != '1)) late_cnt <= late_cnt + LATE_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_time_cmd_sched.sv
// Directed bench for time_cmd_sched: single-command vectors plus fill, flush and resync sequences.
module tb_time_cmd_sched;

    logic        clk;
    logic        rst;
    logic [31:0] master_time;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_time;
    logic        cmd_now;
    logic [7:0]  cmd_data;
    logic        drop_late;
    logic        flush;
    logic        out_stb;
    logic [7:0]  out_data;
    logic        late;
    logic [2:0]  count;
    logic [15:0] late_cnt;

    int checks = 0;
    int errors = 0;
    int late_exp = 0;

    typedef struct {
        logic [31:0] m_start;
        logic [31:0] t;
        logic        now;
        logic        drop;
        logic [7:0]  data;
        logic        exp_stb;
        logic        exp_late;
        logic [31:0] exp_at;
    } vec_t;

    vec_t vecs[8];

    time_cmd_sched #(.DEPTH(4), .CMD_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .master_time (master_time),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_time    (cmd_time),
        .cmd_now     (cmd_now),
        .cmd_data    (cmd_data),
        .drop_late   (drop_late),
        .flush       (flush),
        .out_stb     (out_stb),
        .out_data    (out_data),
        .late        (late),
        .count       (count),
        .late_cnt    (late_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: outputs settle and master_time advances just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        master_time = master_time + 32'd1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_event(input int limit, output logic found, output logic [31:0] at,
                              output logic stb, output logic lt, output logic [7:0] d);
        found = 1'b0; at = '0; stb = 1'b0; lt = 1'b0; d = '0;
        for (int i = 0; i < limit && !found; i++) begin
            step();
            if (out_stb || late) begin
                found = 1'b1;
                at    = master_time;
                stb   = out_stb;
                lt    = late;
                d     = out_data;
            end
        end
    endtask

    task automatic push_one(input logic [31:0] t, input logic now, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_time  = t;
        cmd_now   = now;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_now   = 1'b0;
    endtask

    initial begin
        logic        found;
        logic [31:0] at;
        logic        stb;
        logic        lt;
        logic [7:0]  d;

        vecs[0] = '{32'd0,          32'd100,        1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 32'd101};
        vecs[1] = '{32'd80,         32'd50,         1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 32'd83};
        vecs[2] = '{32'd80,         32'd50,         1'b0, 1'b1, 8'h3D, 1'b0, 1'b1, 32'd83};
        vecs[3] = '{32'hFFFF_FFF0,  32'd5,          1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 32'd6};
        vecs[4] = '{32'h10,         32'hFFFF_FFF0,  1'b0, 1'b0, 8'h61, 1'b1, 1'b1, 32'h13};
        vecs[5] = '{32'd1000,       32'd5000,       1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 32'd1003};
        vecs[6] = '{32'd300,        32'd302,        1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 32'd303};
        vecs[7] = '{32'd400,        32'd401,        1'b0, 1'b1, 8'h88, 1'b0, 1'b1, 32'd403};

        rst = 1'b1; master_time = '0; cmd_valid = 1'b0; cmd_time = '0; cmd_now = 1'b0;
        cmd_data = '0; drop_late = 1'b0; flush = 1'b0;
        repeat (3) step();
        chk("rst_out_stb",   32'(out_stb),   32'd0);
        chk("rst_late",      32'(late),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_late_cnt",  32'(late_cnt),  32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        step();

        // Single-command vectors
        for (int v = 0; v < 8; v++) begin
            master_time = vecs[v].m_start;
            drop_late   = vecs[v].drop;
            push_one(vecs[v].t, vecs[v].now, vecs[v].data);
            wait_event(300, found, at, stb, lt, d);
            chk($sformatf("v%0d_found", v), 32'(found), 32'd1);
            chk($sformatf("v%0d_at", v), at, vecs[v].exp_at);
            chk($sformatf("v%0d_stb", v), 32'(stb), 32'(vecs[v].exp_stb));
            chk($sformatf("v%0d_late", v), 32'(lt), 32'(vecs[v].exp_late));
            if (vecs[v].exp_stb) chk($sformatf("v%0d_data", v), 32'(d), 32'(vecs[v].data));
            if (vecs[v].exp_late) late_exp++;
            step();
            chk($sformatf("v%0d_count", v), 32'(count), 32'd0);
            chk($sformatf("v%0d_late_cnt", v), 32'(late_cnt), 32'(late_exp));
        end
        drop_late = 1'b0;

        // Fill to DEPTH, reject a fifth push, then drain at 2-cycle spacing
        master_time = 32'd150;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_time = 32'd200 + 32'(i);
            cmd_data = 8'hD0 + 8'(i);
            step();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(cmd_ready), 32'd0);
        cmd_time = 32'd100;
        cmd_data = 8'hEE;
        step();
        cmd_valid = 1'b0;
        chk("fill_fifth_ignored", 32'(count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            wait_event(100, found, at, stb, lt, d);
            chk($sformatf("fill%0d_found", k), 32'(found), 32'd1);
            chk($sformatf("fill%0d_at", k), at, 32'd201 + 32'(2 * k));
            chk($sformatf("fill%0d_stb", k), 32'(stb), 32'd1);
            chk($sformatf("fill%0d_late", k), 32'(lt), (k == 0) ? 32'd0 : 32'd1);
            chk($sformatf("fill%0d_data", k), 32'(d), 32'hD0 + 32'(k));
        end
        late_exp += 3;
        step();
        chk("fill_count_end", 32'(count), 32'd0);
        chk("fill_ready_end", 32'(cmd_ready), 32'd1);
        chk("fill_late_cnt", 32'(late_cnt), 32'(late_exp));
        wait_event(20, found, at, stb, lt, d);
        chk("fill_no_extra", 32'(found), 32'd0);

        // Flush in the due WAIT cycle with a simultaneous push
        master_time = 32'd600;
        push_one(32'd603, 1'b0, 8'h44);
        step();
        step();
        flush = 1'b1;
        cmd_valid = 1'b1;
        cmd_time = 32'd610;
        cmd_data = 8'h71;
        step();
        flush = 1'b0;
        cmd_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_stb", 32'(out_stb), 32'd0);
        wait_event(20, found, at, stb, lt, d);
        chk("flush_no_event", 32'(found), 32'd0);
        chk("flush_count_after", 32'(count), 32'd0);

        // Resync backwards: pending T=500 becomes future again
        master_time = 32'd999;
        push_one(32'd500, 1'b0, 8'h5B);
        step();
        master_time = 32'd0;
        wait_event(600, found, at, stb, lt, d);
        chk("rsb_found", 32'(found), 32'd1);
        chk("rsb_at", at, 32'd501);
        chk("rsb_stb", 32'(stb), 32'd1);
        chk("rsb_late", 32'(lt), 32'd0);
        chk("rsb_data", 32'(d), 32'h5B);

        // Resync forwards past a pending target: classified late
        master_time = 32'd398;
        push_one(32'd600, 1'b0, 8'h9A);
        step();
        step();
        master_time = 32'd900;
        wait_event(50, found, at, stb, lt, d);
        chk("rsf_found", 32'(found), 32'd1);
        chk("rsf_at", at, 32'd901);
        chk("rsf_stb", 32'(stb), 32'd1);
        chk("rsf_late", 32'(lt), 32'd1);
        chk("rsf_data", 32'(d), 32'h9A);
        late_exp++;
        step();
        chk("rsf_late_cnt", 32'(late_cnt), 32'(late_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_cmd_sched.md
# time_cmd_sched

Timed command scheduler that sits beside `time_sync` in the `sys_clk_i` domain. It queues up to `DEPTH` commands, each tagged with a 32-bit target time, and releases them in order as single-cycle strobes when `master_time` reaches each target. Late commands are either fired immediately or dropped, as selected by a policy input. It sequences timed actions such as DSP start, GPIO toggles and tune events against the shared master-time counter.

## Interface
- `DEPTH`, 4: queue depth; power of two, 2..16.
- `CMD_W`, 8: command payload width.

- `clk` in 1: system clock (same clock as `master_time`).
- `rst` in 1: synchronous reset, active-high.
- `master_time` in 32: free-running time from `time_sync`; +1 per cycle except when resynced.
- `cmd_valid` in 1: push request.
- `cmd_ready` out 1: queue can accept; equals `count != DEPTH`.
- `cmd_time` in 32: target time.
- `cmd_now` in 1: ignore `cmd_time` and fire as soon as the command reaches head.
- `cmd_data` in CMD_W: payload.
- `drop_late` in 1: 1 = late commands are discarded; 0 = late commands are fired.
- `flush` in 1: empty the queue.
- `out_stb` out 1: command fired (one cycle).
- `out_data` out CMD_W: payload of the fired command; valid with `out_stb`.
- `late` out 1: one-cycle pulse; head was past its time when evaluated.
- `count` out $clog2(DEPTH)+1: queue occupancy.
- `late_cnt` out 16: saturating count of late events.

## Operation
- Queue is an in-order FIFO storing {`cmd_now`, `cmd_time`, `cmd_data`}. A push occurs when `cmd_valid & cmd_ready`. A push while full is ignored and nothing is stored.
- Head compare: `diff = cmd_time - master_time`, computed mod 2^32.
  - due = `diff == 0`
  - late = `diff[31]`, meaning the target is up to 2^31 cycles in the past
  - future = otherwise
- FSM states:
  - IDLE: `count == 0`.
    - Goes to WAIT when `count > 0`.
  - WAIT: head is evaluated every cycle.
    - If `now` or due: go to FIRE with `out_stb <= 1` and `late <= 0`.
    - If late and `drop_late = 0`: go to FIRE with `out_stb <= 1` and `late <= 1`.
    - If late and `drop_late = 1`: go to FIRE with `out_stb <= 0` and `late <= 1`.
    - If future: stay in WAIT.
    - The head is popped on the WAIT→FIRE transition. `out_data` is loaded with the head payload.
  - FIRE: lasts one cycle. `out_stb` and `late` drop. Goes to WAIT if `count > 0`, else IDLE.
- `late_cnt` increments on every `late` pulse and saturates at 0xFFFF. It is cleared only by `rst`.
- `flush` (highest priority, same cycle):
  - sets `count`, the pointers and the FSM to IDLE;
  - ignores any push in the same cycle;
  - suppresses an in-flight WAIT→FIRE decision, so no strobe results.
  - An `out_stb` already registered still completes its single cycle.
- A push and a pop in the same cycle are legal. Occupancy is unchanged, and `cmd_ready` is evaluated from pre-update `count`.
- When `master_time` jumps (PPS resync or external sync), the compare uses the new value on the next cycle. A pending command whose target was skipped over is classified late.
- Reset values: `out_stb = 0`, `late = 0`, `out_data = 0`, `count = 0`, `late_cnt = 0`, `cmd_ready = 1`, FSM = IDLE.

## Timing
- Fire latency: if `master_time == T` in the WAIT cycle, `out_stb` is high in the next cycle, when `master_time == T+1`. Software compensates by programming T−1.
- Push-to-eligible: a pushed entry is visible at head one cycle after the push. Minimum push-to-strobe with `cmd_now` is 3 cycles.
- Back-to-back fires: minimum spacing is 2 cycles (WAIT, FIRE). A second command at the same T therefore fires 2 cycles later and is flagged late.
- `cmd_ready` is combinational from `count`. All other outputs are registered.

## Structure
- Shared package `time_pkg`: FSM state encoding (IDLE, WAIT, FIRE), `TIME_W = 32`, `LATE_CNT_W = 16`.
- One sub-module, `cmd_fifo`: a synchronous FIFO with `DEPTH`/`WIDTH` parameters, push/pop/flush, occupancy output and head word output (first-word fall-through).
- The scheduler FSM, compare, and `late_cnt` live in `time_cmd_sched`.

## Test plan
- Reset then `master_time` free-running from 0; push T=100, data=0xA5 → `out_stb` only at `master_time == 101`, `out_data = 0xA5`, `late = 0`, `count` 1→0.
- Push T=50 when `master_time = 80`, `drop_late = 0` → `out_stb` + `late` in the same cycle within 3 cycles of the push; `late_cnt = 1`. Repeat with `drop_late = 1` → `late` pulse, no `out_stb`, `late_cnt = 2`.
- Fill `DEPTH = 4` with T=200,201,202,203 → `cmd_ready = 0` and a fifth push is ignored. Observe fires at 201, 203 (late), 205 (late), 207 (late); `late_cnt` = 3.
- Wrap: `master_time` = 0xFFFFFFF0, push T=0x00000005 → fires at `master_time = 6`, not late. Push T=0xFFFFFFF0 at `master_time = 0x10` → late.
- `flush` asserted in the WAIT cycle where head is due, with a simultaneous push → no `out_stb`, `count = 0`, pushed command absent.
- PPS resync drops `master_time` from 1000 to 0 with pending T=500 → not late, fires at `master_time = 501`. Resync from 400 to 900 with pending T=600 → late.
